// File: rtl/multicycle_data_path.sv
// Multicycle MIPS-subset core: one shared memory port, one instruction
// in flight, walking FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read instruction at PC; on ack latch IR and advance PC by 4
// DECODE | read rs/rt into A/B, sign-extend imm; trap halt/undefined ops
// EXEC   | ALU op, branch/jump resolution, or load/store address calc
// MEM    | data access at latched address; store data comes from B
// WB     | write ALU/load result to rd (R-type) or rt (I-type)
// HALT   | frozen, no memory traffic; left only through reset
module multicycle_data_path #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] pc_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] pc, a, b, imm, res;
    logic [31:0]       ir;
    logic [DATA_W-1:0] rf [32];
    logic              illegal_q;
    // Set by every reset edge so the cycle after reset never requests,
    // which also drops any transfer that was pending when reset hit.
    logic              req_block;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [4:0]        unused_shamt;
    logic [DATA_W-1:0] imm_sext, jump_tgt, alu_res;
    logic              dec_legal, bus_done;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign unused_shamt = ir[10:6];
    assign funct        = ir[5:0];
    assign imm_sext     = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign jump_tgt     = {pc[DATA_W-1:28], ir[25:0], 2'b00};

    assign halted  = (state == HALT);
    assign illegal = illegal_q;
    assign pc_out  = pc;

    // Opcode/funct legality check used by DECODE.
    always_comb begin
        dec_legal = 1'b0;
        case (opcode)
            OP_RTYPE: dec_legal = funct inside {F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: dec_legal = 1'b1;
            default:  dec_legal = 1'b0;
        endcase
    end

    // ALU: signed compares yield a zero-extended 0/1.
    always_comb begin
        alu_res = a + b;
        if (opcode == OP_ADDI) begin
            alu_res = a + imm;
        end else if (opcode == OP_SLTI) begin
            alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(imm))};
        end else begin
            case (funct)
                F_SUB:   alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
                default: alu_res = a + b;
            endcase
        end
    end

    // Next state, memory port drive and register-file write port.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = b;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = res;
        bus_done  = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = !req_block;
                bus_done = mem_req && mem_ack;
                if (bus_done) state_nxt = DECODE;
            end
            DECODE: begin
                if (opcode == OP_HALT || !dec_legal) state_nxt = HALT;
                else                                 state_nxt = EXEC;
            end
            EXEC: begin
                case (opcode)
                    OP_BEQ, OP_J: state_nxt = FETCH;
                    OP_JAL: begin
                        state_nxt = FETCH;
                        rf_we     = 1'b1;
                        rf_waddr  = 5'd31;
                        rf_wdata  = pc;
                    end
                    OP_LW, OP_SW: state_nxt = MEM;
                    OP_RTYPE:     state_nxt = (funct == F_JR) ? FETCH : WB;
                    default:      state_nxt = WB;
                endcase
            end
            MEM: begin
                mem_req  = !req_block;
                mem_we   = (opcode == OP_SW);
                mem_addr = res;
                bus_done = mem_req && mem_ack;
                if (bus_done) state_nxt = (opcode == OP_SW) ? FETCH : WB;
            end
            WB: begin
                state_nxt = FETCH;
                rf_we     = 1'b1;
                rf_waddr  = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata  = res;
            end
            HALT: state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Architectural state; R0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            imm       <= '0;
            res       <= '0;
            illegal_q <= 1'b0;
            req_block <= 1'b1;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state     <= state_nxt;
            req_block <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus_done) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + DATA_W'(4);
                    end
                end
                DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= imm_sext;
                    if (opcode != OP_HALT && !dec_legal) illegal_q <= 1'b1;
                end
                EXEC: begin
                    res <= alu_res;
                    case (opcode)
                        OP_BEQ:       if (a == b) pc <= pc + {imm[DATA_W-3:0], 2'b00};
                        OP_J, OP_JAL: pc <= jump_tgt;
                        OP_LW, OP_SW: res <= a + imm;
                        OP_RTYPE:     if (funct == F_JR) pc <= a;
                        default: ;
                    endcase
                end
                MEM: begin
                    if (bus_done && opcode == OP_LW) res <= mem_rdata;
                end
                default: ;
            endcase
            if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_data_path.sv
// Bench for multicycle_data_path: a 32-bit and a 64-bit instance share the
// clock, each with a behavioural memory. Register contents are observed by
// storing them; every expected store is queued when a program is loaded
// and a monitor pops and compares each store the core performs.
module tb_multicycle_data_path;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst32, rst64;

    logic        req32, we32, ack32, halted32, ill32;
    logic [31:0] addr32, wd32, rdata32, pc32;
    logic        req64, we64, ack64, halted64, ill64;
    logic [63:0] addr64, wd64, rdata64, pc64;

    logic [31:0] mem32 [256];
    logic [63:0] mem64 [256];
    exp_t        exp32_q[$];
    exp_t        exp64_q[$];

    int          errors = 0;
    int          checks = 0;
    int          ws32   = 0;
    int          cnt32  = 0;
    logic [31:0] cap_addr, cap_wd;
    logic        cap_we;

    always #5 clk = ~clk;

    multicycle_data_path #(.DATA_W(32), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .rst(rst32), .mem_req(req32), .mem_we(we32),
        .mem_addr(addr32), .mem_wdata(wd32), .mem_rdata(rdata32),
        .mem_ack(ack32), .halted(halted32), .illegal(ill32), .pc_out(pc32)
    );

    multicycle_data_path #(.DATA_W(64), .RESET_PC(64'h40)) dut64 (
        .clk(clk), .rst(rst64), .mem_req(req64), .mem_we(we64),
        .mem_addr(addr64), .mem_wdata(wd64), .mem_rdata(rdata64),
        .mem_ack(ack64), .halted(halted64), .illegal(ill64), .pc_out(pc64)
    );

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push32(input logic [31:0] addr, input logic [31:0] data);
        exp32_q.push_back('{addr: {32'h0, addr}, data: {32'h0, data}});
    endtask

    // 32-bit memory: ws32 wait states per access, request must hold still.
    always @(negedge clk) begin
        ack32 = 1'b0;
        if (req32) begin
            if (cnt32 == 0) begin
                cap_addr = addr32;
                cap_we   = we32;
                cap_wd   = wd32;
            end else begin
                check("req_stable", {cap_we, cap_addr, cap_wd}, {we32, addr32, wd32});
            end
            if (cnt32 >= ws32) begin
                ack32 = 1'b1;
                cnt32 = 0;
                if (we32) mem32[addr32[9:2]] = wd32;
                else      rdata32 = mem32[addr32[9:2]];
            end else begin
                cnt32++;
            end
        end else begin
            cnt32 = 0;
        end
    end

    // 64-bit memory: zero wait states.
    always @(negedge clk) begin
        ack64 = 1'b0;
        if (req64) begin
            ack64 = 1'b1;
            if (we64) mem64[addr64[9:2]] = wd64;
            else      rdata64 = mem64[addr64[9:2]];
        end
    end

    // Monitor: every completed store is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (req32 && we32 && ack32) begin
            if (exp32_q.size() == 0) begin
                check("unexpected_store32", {32'h0, addr32}, 64'hDEAD);
            end else begin
                e = exp32_q.pop_front();
                check("store32_addr", {32'h0, addr32}, e.addr);
                check("store32_data", {32'h0, wd32}, e.data);
            end
        end
        if (req64 && we64 && ack64) begin
            if (exp64_q.size() == 0) begin
                check("unexpected_store64", addr64, 64'hDEAD);
            end else begin
                e = exp64_q.pop_front();
                check("store64_addr", addr64, e.addr);
                check("store64_data", wd64, e.data);
            end
        end
    end

    task automatic wait_halt32(input string name, input int budget, output int n);
        n = 0;
        while (!halted32 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, halted32, 1'b1);
    endtask

    task automatic clear32;
        for (int k = 0; k < 256; k++) mem32[k] = 32'h0;
    endtask

    initial begin
        int n;
        logic stuck;
        logic [31:0] pc_hold;
        rst32 = 1'b0;
        rst64 = 1'b0;

        // Program A: addi/addi/add/halt with zero wait states.
        clear32();
        mem32[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem32[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem32[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
        mem32[3] = enc_j(6'h3F, 26'h0);
        repeat (2) @(negedge clk);
        check("reset_mem_req", req32, 1'b0);
        check("reset_halted", halted32, 1'b0);
        check("reset_illegal", ill32, 1'b0);
        check("reset_pc", pc32, 32'h0);
        check("reset_pc64", pc64, 64'h40);
        rst32 = 1'b1;
        n = 0;
        while (!req32 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_fetch_delay", n, 1);
        check("first_fetch_addr", addr32, 32'h0);
        check("first_fetch_we", we32, 1'b0);
        wait_halt32("progA_halt", 100, n);
        check("progA_cycles", n, 14);
        check("progA_pc", pc32, 32'd16);
        check("progA_illegal", ill32, 1'b0);
        pc_hold = pc32;
        stuck = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (req32 || pc32 != pc_hold) stuck = 1'b1;
        end
        check("halt_frozen", stuck, 1'b0);

        // Program B: ALU ops, sw/lw with 3 wait states, branches, jal, jr, j.
        rst32 = 1'b0;
        @(negedge clk);
        clear32();
        mem32[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem32[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem32[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
        mem32[3]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h200);   push32(32'h200, 32'd2);
        mem32[4]  = enc_r(6'h2A, 5'd2, 5'd1, 5'd5);
        mem32[5]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h204);   push32(32'h204, 32'd1);
        mem32[6]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        mem32[7]  = enc_i(6'h2B, 5'd0, 5'd0, 16'h208);   push32(32'h208, 32'd0);
        mem32[8]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h8);     push32(32'h8, 32'd5);
        mem32[9]  = enc_i(6'h23, 5'd0, 5'd4, 16'h8);
        mem32[10] = enc_i(6'h2B, 5'd0, 5'd4, 16'h20C);   push32(32'h20C, 32'd5);
        mem32[11] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        mem32[12] = enc_i(6'h2B, 5'd0, 5'd1, 16'h210);
        mem32[13] = enc_i(6'h2B, 5'd0, 5'd1, 16'h210);
        mem32[14] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
        mem32[15] = enc_i(6'h2B, 5'd0, 5'd1, 16'h214);   push32(32'h214, 32'd5);
        mem32[16] = enc_j(6'h03, 26'h40);
        mem32[64] = enc_i(6'h2B, 5'd0, 5'd31, 16'h218);  push32(32'h218, 32'h44);
        mem32[65] = enc_r(6'h22, 5'd1, 5'd2, 5'd6);
        mem32[66] = enc_i(6'h2B, 5'd0, 5'd6, 16'h21C);   push32(32'h21C, 32'd8);
        mem32[67] = enc_r(6'h24, 5'd1, 5'd2, 5'd7);
        mem32[68] = enc_i(6'h2B, 5'd0, 5'd7, 16'h220);   push32(32'h220, 32'd5);
        mem32[69] = enc_r(6'h25, 5'd1, 5'd2, 5'd8);
        mem32[70] = enc_i(6'h2B, 5'd0, 5'd8, 16'h224);   push32(32'h224, 32'hFFFF_FFFD);
        mem32[71] = enc_i(6'h0A, 5'd2, 5'd9, 16'd0);
        mem32[72] = enc_i(6'h2B, 5'd0, 5'd9, 16'h228);   push32(32'h228, 32'd1);
        mem32[73] = enc_i(6'h08, 5'd0, 5'd10, 16'h180);
        mem32[74] = enc_r(6'h08, 5'd10, 5'd0, 5'd0);
        mem32[75] = enc_i(6'h2B, 5'd0, 5'd0, 16'h22C);
        mem32[96] = enc_j(6'h02, 26'h30);
        mem32[48] = enc_j(6'h3F, 26'h0);
        ws32 = 3;
        rst32 = 1'b1;
        wait_halt32("progB_halt", 3000, n);
        check("progB_pc", pc32, 32'hC4);
        check("progB_illegal", ill32, 1'b0);
        check("progB_stores_done", exp32_q.size(), 0);
        check("progB_mem8", mem32[2], 32'd5);

        // Program C: undefined opcode traps with illegal set.
        rst32 = 1'b0;
        @(negedge clk);
        clear32();
        mem32[0] = enc_i(6'h2A, 5'd0, 5'd0, 16'd0);
        ws32 = 0;
        rst32 = 1'b1;
        wait_halt32("progC_halt", 50, n);
        check("progC_illegal", ill32, 1'b1);
        check("progC_pc", pc32, 32'd4);
        stuck = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (req32) stuck = 1'b1;
        end
        check("progC_no_req", stuck, 1'b0);

        // Program D: reset while a load waits in MEM.
        rst32 = 1'b0;
        @(negedge clk);
        clear32();
        mem32[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h40);
        mem32[1] = enc_j(6'h3F, 26'h0);
        ws32 = 20;
        rst32 = 1'b1;
        n = 0;
        while (!(req32 && addr32 == 32'h40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("progD_in_mem", {req32, addr32}, {1'b1, 32'h40});
        rst32 = 1'b0;
        @(negedge clk);
        check("progD_req_after_rst", req32, 1'b0);
        check("progD_illegal_clr", ill32, 1'b0);
        ws32 = 0;
        rst32 = 1'b1;
        n = 0;
        while (!req32 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("progD_refetch", {req32, we32, addr32}, {1'b1, 1'b0, 32'h0});
        wait_halt32("progD_halt", 100, n);
        check("progD_pc", pc32, 32'd8);

        // 64-bit instance, RESET_PC = 0x40.
        for (int k = 0; k < 256; k++) mem64[k] = 64'h0;
        mem64[16] = {32'h0, enc_i(6'h08, 5'd0, 5'd1, 16'd5)};
        mem64[17] = {32'h0, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD)};
        mem64[18] = {32'h0, enc_r(6'h20, 5'd1, 5'd2, 5'd3)};
        mem64[19] = {32'h0, enc_i(6'h2B, 5'd0, 5'd3, 16'h200)};
        exp64_q.push_back('{addr: 64'h200, data: 64'd2});
        mem64[20] = {32'h0, enc_i(6'h08, 5'd0, 5'd4, 16'hFFFF)};
        mem64[21] = {32'h0, enc_i(6'h08, 5'd4, 5'd5, 16'd0)};
        mem64[22] = {32'h0, enc_i(6'h2B, 5'd0, 5'd5, 16'h208)};
        exp64_q.push_back('{addr: 64'h208, data: 64'hFFFF_FFFF_FFFF_FFFF});
        mem64[23] = {32'h0, enc_j(6'h3F, 26'h0)};
        rst64 = 1'b1;
        n = 0;
        while (!halted64 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w64_halt", halted64, 1'b1);
        check("w64_pc", pc64, 64'h60);
        check("w64_illegal", ill64, 1'b0);
        check("w64_stores_done", exp64_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
